// File: rtl/uart_pkg.sv
// Shared UART definitions for the transmitter and receiver.
// Define UART_TX_PARITY_EN to add an even-parity bit to the transmit frame.
package uart_pkg;

    localparam int UART_DATA_BITS            = 8;
    localparam int UART_DEFAULT_CLKS_PER_BIT = 868;

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} tx_state_t;
`else
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;
`endif

    function automatic logic even_parity(input logic [UART_DATA_BITS-1:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Count-based byte queue for the UART transmitter; dout shows the head entry while not empty.
// A push while full is dropped regardless of a same-edge pop.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = UART_DATA_BITS
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    output logic             full
);

    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PW:0]      count_q, count_d;
    logic             do_push, do_pop;

    assign full    = (count_q == (PW+1)'(DEPTH));
    assign empty   = (count_q == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr_q];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_comb begin
        wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = do_pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d  = count_q;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_q] <= din;
        end
    end

endmodule

// File: rtl/uart_tx_buffered.sv
// Buffered 8N1 UART transmitter, LSB first, idle-high line, back-to-back frames from the queue.
// Define UART_TX_PARITY_EN to insert an even-parity bit between the data bits and the stop bit.
module uart_tx_buffered
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_DEFAULT_CLKS_PER_BIT,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_TX_DV,
    input  logic [7:0] i_TX_Byte,
    output logic       o_TX_Ready,
    output logic       o_TX_Active,
    output logic       o_TX_Serial,
    output logic       o_TX_Done
);

    localparam int                CNT_W   = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);

    tx_state_t                   state_q, state_d;
    logic [CNT_W-1:0]            cnt_q, cnt_d;
    logic [2:0]                  bit_idx_q, bit_idx_d;
    logic [UART_DATA_BITS-1:0]   shift_q, shift_d;
    logic                        parity_q, parity_d;
    logic                        serial_q, serial_d;
    logic                        active_q, active_d;
    logic                        done_q, done_d;

    logic                        fifo_pop, fifo_empty, fifo_full;
    logic [UART_DATA_BITS-1:0]   fifo_dout;
    logic                        bit_end;

    uart_tx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (UART_DATA_BITS)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (i_TX_DV),
        .din   (i_TX_Byte),
        .pop   (fifo_pop),
        .dout  (fifo_dout),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

    assign bit_end = (cnt_q == CNT_MAX);

    always_comb begin
        state_d   = state_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        parity_d  = parity_q;
        fifo_pop  = 1'b0;
        cnt_d     = (state_q != IDLE && !bit_end) ? cnt_q + 1'b1 : '0;

        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    shift_d  = fifo_dout;
                    parity_d = even_parity(fifo_dout);
                    state_d  = START;
                end
            end
            START: begin
                if (bit_end) begin
                    bit_idx_d = '0;
                    state_d   = DATA;
                end
            end
            DATA: begin
                if (bit_end) begin
                    if (bit_idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end else begin
                        shift_d   = shift_q >> 1;
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (bit_end) begin
                    state_d = STOP;
                end
            end
`endif
            STOP: begin
                // Chain straight into the next frame so queued bytes leave with no idle gap.
                if (bit_end) begin
                    if (!fifo_empty) begin
                        fifo_pop = 1'b1;
                        shift_d  = fifo_dout;
                        parity_d = even_parity(fifo_dout);
                        state_d  = START;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        case (state_d)
            START:   serial_d = 1'b0;
            DATA:    serial_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
            PARITY:  serial_d = parity_d;
`endif
            default: serial_d = 1'b1;
        endcase

        active_d = (state_d != IDLE);
        done_d   = (state_d == STOP) && (cnt_d == CNT_MAX);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            parity_q  <= 1'b0;
            serial_q  <= 1'b1;
            active_q  <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            parity_q  <= parity_d;
            serial_q  <= serial_d;
            active_q  <= active_d;
            done_q    <= done_d;
        end
    end

    assign o_TX_Ready  = !fifo_full;
    assign o_TX_Active = active_q;
    assign o_TX_Serial = serial_q;
    assign o_TX_Done   = done_q;

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Directed bench for uart_tx_buffered with CLKS_PER_BIT=4, FIFO_DEPTH=4.
// Outputs are sampled on the falling edge; inputs change on the falling edge.
module tb_uart_tx_buffered;

    localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif
    localparam int FL = NBITS * CPB;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       dv  = 1'b0;
    logic [7:0] txb = 8'h00;
    logic       ready, active, serial, done;

    int total = 0;
    int bad   = 0;

    uart_tx_buffered #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .i_TX_DV     (dv),
        .i_TX_Byte   (txb),
        .o_TX_Ready  (ready),
        .o_TX_Active (active),
        .o_TX_Serial (serial),
        .o_TX_Done   (done)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %b want %b", tag, obs, exp);
        end
    endtask

    // Line level for bit slot idx of a frame carrying b: start, 8 data LSB first, [parity], stop.
    function automatic logic exp_bit(input logic [7:0] b, input int idx);
        if (idx == 0)         return 1'b0;
        if (idx <= 8)         return b[idx-1];
        if (idx == NBITS - 1) return 1'b1;
        return ^b;
    endfunction

    // Checks one whole frame, starting at the falling edge after the frame's first clock edge.
    task automatic expect_frame(input logic [7:0] b, input int lo_s, input int lo_e);
        for (int c = 0; c < FL; c++) begin
            @(negedge clk);
            chk($sformatf("serial b=%02h c=%0d", b, c), serial, exp_bit(b, c / CPB));
            chk($sformatf("done b=%02h c=%0d", b, c), done, (c == FL - 1));
            chk($sformatf("active b=%02h c=%0d", b, c), active, 1'b1);
            chk($sformatf("ready b=%02h c=%0d", b, c), ready, !(c >= lo_s && c < lo_e));
        end
        $display("frame %02h checked (%0d cycles)", b, FL);
    endtask

    task automatic idle_check(input string tag, input int n);
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            chk($sformatf("%s serial c=%0d", tag, c), serial, 1'b1);
            chk($sformatf("%s active c=%0d", tag, c), active, 1'b0);
            chk($sformatf("%s done c=%0d", tag, c), done, 1'b0);
        end
    endtask

    task automatic send(input logic [7:0] b);
        dv  = 1'b1;
        txb = b;
        @(negedge clk);
        dv  = 1'b0;
        txb = ~b;
        chk($sformatf("latency b=%02h", b), serial, 1'b1);
        expect_frame(b, 0, 0);
    endtask

    initial begin
        // Reset held for three cycles
        repeat (3) @(negedge clk);
        chk("rst serial", serial, 1'b1);
        chk("rst ready", ready, 1'b1);
        chk("rst active", active, 1'b0);
        chk("rst done", done, 1'b0);
        rst = 1'b0;
        idle_check("post_rst", 3);
        $display("reset hold checked");

        // Asynchronous reset between edges while the start bit is on the line
        dv  = 1'b1;
        txb = 8'h5A;
        @(negedge clk);
        dv  = 1'b0;
        @(negedge clk);
        chk("pre_async serial", serial, 1'b0);
        chk("pre_async active", active, 1'b1);
        #2 rst = 1'b1;
        #1;
        chk("async serial", serial, 1'b1);
        chk("async active", active, 1'b0);
        chk("async ready", ready, 1'b1);
        @(negedge clk);
        rst = 1'b0;
        idle_check("after_async", 6);
        $display("async reset checked");

        // Single byte, with i_TX_Byte changed right after the accepting edge
        send(8'hA5);
        idle_check("after_a5", 5);

        // Back-to-back frames with no idle gap
        fork
            begin
                dv = 1'b1; txb = 8'h00;
                @(negedge clk);
                txb = 8'hFF;
                @(negedge clk);
                txb = 8'h55;
                @(negedge clk);
                dv = 1'b0;
            end
            begin
                @(negedge clk);
                chk("b2b latency", serial, 1'b1);
                expect_frame(8'h00, 0, 0);
                expect_frame(8'hFF, 0, 0);
                expect_frame(8'h55, 0, 0);
            end
        join
        idle_check("after_b2b", 5);

        // Overflow: 8 pushes, first 5 survive, Ready low from the filling edge to the first pop
        fork
            begin
                for (int i = 0; i < 8; i++) begin
                    dv  = 1'b1;
                    txb = 8'h10 + 8'(i);
                    @(negedge clk);
                end
                dv = 1'b0;
            end
            begin
                @(negedge clk);
                chk("ovf latency", serial, 1'b1);
                chk("ovf ready0", ready, 1'b1);
                expect_frame(8'h10, 3, FL);
                for (int i = 1; i < 5; i++) begin
                    expect_frame(8'h10 + 8'(i), 0, 0);
                end
            end
        join
        idle_check("after_ovf", 10);

        // Reset during data bit 3 of 0x3C with two more bytes queued
        fork
            begin
                dv = 1'b1; txb = 8'h3C;
                @(negedge clk);
                txb = 8'h11;
                @(negedge clk);
                txb = 8'h22;
                @(negedge clk);
                dv = 1'b0;
            end
            begin
                @(negedge clk);
                for (int c = 0; c < 18; c++) begin
                    @(negedge clk);
                    chk($sformatf("pre_rst serial c=%0d", c), serial, exp_bit(8'h3C, c / CPB));
                end
                chk("pre_rst active", active, 1'b1);
            end
        join
        #2 rst = 1'b1;
        #1;
        chk("midrst serial", serial, 1'b1);
        chk("midrst active", active, 1'b0);
        chk("midrst done", done, 1'b0);
        chk("midrst ready", ready, 1'b1);
        @(negedge clk);
        rst = 1'b0;
        idle_check("after_midrst", 50);
        $display("mid-frame reset checked");
        send(8'h81);
        idle_check("after_81", 3);

`ifdef UART_TX_PARITY_EN
        send(8'h07);
        idle_check("after_07", 3);
        send(8'h03);
        idle_check("after_03", 3);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_tx_buffered.md
Name: uart_tx_buffered

Overview:
- UART transmitter: the send side of the serial link our UART receiver handles. 8N1 framing, LSB first, line idles high.
- Small FIFO in front of the shift engine so producers (watch control logic, debug) can queue bytes without waiting on each frame.
- Output o_TX_Serial drives the board TX pin; bit timing matches the receiver's CLKS_PER_BIT convention.

Parameters:
- CLKS_PER_BIT, 868, clk cycles per serial bit (100 MHz / 115200); legal range >= 2.
- FIFO_DEPTH, 4, byte entries in the TX queue; power of 2, >= 2.

Ports:
- clk  in  1  system clock, all logic on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- i_TX_DV  in  1  write strobe; byte accepted on an edge where i_TX_DV && o_TX_Ready.
- i_TX_Byte  in  8  byte to queue.
- o_TX_Ready  out  1  FIFO not full (registered).
- o_TX_Active  out  1  high from the first start-bit cycle to the last stop-bit cycle of any frame.
- o_TX_Serial  out  1  serial line.
- o_TX_Done  out  1  one-cycle pulse per completed frame.

Behaviour:
- Reset (async assert): o_TX_Serial=1, o_TX_Active=0, o_TX_Done=0, o_TX_Ready=1, FIFO empty, FSM=IDLE, counters 0. Mid-frame reset aborts the frame; the line goes high immediately; no Done pulse.
- Baud counter width $clog2(CLKS_PER_BIT); counts 0..CLKS_PER_BIT-1 per bit; the bit index is 3 bits.
- FSM states: IDLE, START, DATA, STOP (plus PARITY, see Optional Feature).
- IDLE: line=1. If FIFO is non-empty at an edge, pop the head into the shift register and enter START.
- START: line=0 for CLKS_PER_BIT cycles, then DATA.
- DATA: line=shift[0] for CLKS_PER_BIT cycles per bit, bits 0..7 in order, then STOP.
- STOP: line=1 for CLKS_PER_BIT cycles. o_TX_Done=1 on the final STOP cycle. On the same edge that leaves STOP:
  - FIFO non-empty: pop and go directly to START (no idle gap between frames).
  - FIFO empty: go to IDLE.
- Latency: byte written at edge k into an empty FIFO with FSM in IDLE -> o_TX_Serial falls after edge k+1.
- Frame length: exactly 10*CLKS_PER_BIT cycles.
- FIFO: count-based with wrapping read/write pointers. o_TX_Ready = !full, computed from registered state.
- Push while full is ignored and the byte is dropped, even if a pop occurs on the same edge.
- Simultaneous push and pop when not full: count unchanged and both take effect.
- i_TX_Byte is sampled only at the accepting edge; later changes do not affect queued data.
- o_TX_Active falls on the edge entering IDLE. It stays high across back-to-back frames.

Optional Feature:
- Macro UART_TX_PARITY_EN.
- Defined: PARITY state inserted between DATA and STOP, one bit period, line = even parity (XOR of the 8 data bits). Frame = 11*CLKS_PER_BIT cycles. Done still pulses on the final STOP cycle.
- Undefined: no PARITY state, 8N1 framing as above; the state encoding omits PARITY.

Decomposition:
- Shared package uart_pkg holds:
  - the tx_state_t enum (IDLE, START, DATA, PARITY, STOP);
  - UART_DATA_BITS=8;
  - UART_DEFAULT_CLKS_PER_BIT=868.
- The receiver also imports uart_pkg for CLKS_PER_BIT/data-width consistency.
- One sub-module: uart_tx_fifo (parameter DEPTH; ports clk, rst, push, din, pop, dout, empty, full). dout is the head entry, valid when !empty.
- The FSM and shifter stay in uart_tx_buffered.

Test Plan (CLKS_PER_BIT=4, FIFO_DEPTH=4 unless noted):
- Reset: hold rst 3 cycles -> o_TX_Serial=1, o_TX_Ready=1, o_TX_Active=0, o_TX_Done=0. Assert rst asynchronously between edges -> outputs change before the next edge.
- Single byte 0xA5 -> line sequence 0,1,0,1,0,0,1,0,1,1, each held exactly 4 cycles (40 total). One Done pulse on cycle 40. Active high for exactly 40 cycles.
- Back-to-back 0x00, 0xFF, 0x55 pushed on consecutive cycles -> 120 contiguous frame cycles with no idle gap, 3 Done pulses 40 cycles apart, decoded bytes match in order.
- Overflow: push 0x10..0x17 on 8 consecutive cycles from idle -> first 5 bytes (0x10..0x14) transmitted, remaining 3 dropped. o_TX_Ready low from the edge the FIFO fills until the first pop.
- Reset during DATA bit 3 of 0x3C with 2 bytes queued -> line high immediately, FIFO empty, no Done. A subsequent push of 0x81 transmits correctly.
- With UART_TX_PARITY_EN defined, send 0x07 -> parity bit 1, frame 44 cycles. Send 0x03 -> parity bit 0.
